// File: rtl/uart_ctrl.sv
// UART controller: bus decode for TXD/RXD/CON, a small TX FIFO feeding the sender
// over a start/busy handshake, RX byte latch with overrun tracking, and the UART irq.
`timescale 1ns/1ps
module uart_ctrl #(
  parameter int unsigned FIFO_AW  = 2,
  parameter logic [31:0] TXD_ADDR = 32'h4000_0018,
  parameter logic [31:0] RXD_ADDR = 32'h4000_001C,
  parameter logic [31:0] CON_ADDR = 32'h4000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        irq
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = FIFO_AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, SEND} tx_state_e;

  tx_state_e         state_q, state_d;
  logic [7:0]        fifo_mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full;
  logic              txd_wr, rxd_rd, con_rd, con_wr;
  logic              push, pop_c, done_set_c;
  logic              tx_ie, rx_ie, rx_full, tx_done, rx_ovr, tx_ovf;
  logic [7:0]        rx_buf;
  logic [7:0]        con;
  logic              unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign txd_wr = wr && (addr == TXD_ADDR);
  assign con_wr = wr && (addr == CON_ADDR);
  assign rxd_rd = rd && (addr == RXD_ADDR);
  assign con_rd = rd && (addr == CON_ADDR);

  // Extra pointer bit distinguishes full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  // A pop in the same cycle frees the slot, so a write to a full FIFO is still taken.
  assign push = txd_wr && (!fifo_full || pop_c);

  assign con = {fifo_empty && (state_q == IDLE), tx_ovf, rx_ovr, tx_done,
                rx_full, fifo_full, rx_ie, tx_ie};

  always_comb begin
    rdata = 32'h0;
    if (rxd_rd)      rdata = {24'h0, rx_buf};
    else if (con_rd) rdata = {24'h0, con};
  end

  // TX FSM next-state and handshake decisions.
  always_comb begin
    state_d    = state_q;
    pop_c      = 1'b0;
    done_set_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          pop_c   = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (tx_busy) state_d = SEND;
      SEND: begin
        if (!tx_busy) begin
          done_set_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Storage needs no reset: pointers define the valid contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_data  <= 8'h0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= pop_c;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c) begin
        rd_ptr  <= rd_ptr + PW'(1);
        tx_data <= fifo_mem[rd_ptr[FIFO_AW-1:0]];
      end
    end
  end

  // Status and control bits; a set event beats a clearing read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ie   <= 1'b0;
      rx_ie   <= 1'b0;
      rx_full <= 1'b0;
      tx_done <= 1'b0;
      rx_ovr  <= 1'b0;
      tx_ovf  <= 1'b0;
      rx_buf  <= 8'h0;
      irq     <= 1'b0;
    end else begin
      if (con_wr) begin
        tx_ie <= wdata[0];
        rx_ie <= wdata[1];
      end
      if (rx_valid) begin
        rx_buf  <= rx_data;
        rx_full <= 1'b1;
      end else if (rxd_rd) begin
        rx_full <= 1'b0;
      end
      if (done_set_c)                        tx_done <= 1'b1;
      else if (con_rd)                       tx_done <= 1'b0;
      if (rx_valid && rx_full && !rxd_rd)    rx_ovr  <= 1'b1;
      else if (con_rd)                       rx_ovr  <= 1'b0;
      if (txd_wr && fifo_full && !pop_c)     tx_ovf  <= 1'b1;
      else if (con_rd)                       tx_ovf  <= 1'b0;
      irq <= (tx_ie && tx_done) || (rx_ie && rx_full);
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: a behavioural sender model plus a queue of
// expected bytes popped whenever the controller pulses tx_start.
`timescale 1ns/1ps
module tb_uart_ctrl;

  localparam logic [31:0] TXD = 32'h4000_0018;
  localparam logic [31:0] RXD = 32'h4000_001C;
  localparam logic [31:0] CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  tx_data, rx_data;
  logic        tx_start, tx_busy, rx_valid, irq;

  logic        hold_busy;
  int          busy_len;
  int          busy_cnt;
  int          total = 0;
  int          bad = 0;
  int          starts = 0;
  logic        prev_start = 1'b0;
  logic [7:0]  exp_q[$];

  uart_ctrl dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
  );

  always #10 clk = ~clk;

  // Sender model: busy rises the cycle after tx_start and lasts busy_len cycles.
  always @(posedge clk or posedge reset) begin
    if (reset)         busy_cnt <= 0;
    else if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = hold_busy | (busy_cnt != 0);

  // Scoreboard: every start pulse must carry the next expected byte.
  always @(negedge clk) begin
    if (tx_start) begin
      starts = starts + 1;
      total = total + 1;
      if (prev_start) begin
        bad = bad + 1;
        $display("FAIL start_pulse_width got=2+ cycles exp=1");
      end else if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_start got=%h exp=none", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          bad = bad + 1;
          $display("FAIL tx_byte got=%h exp=%h", tx_data, e);
        end
      end
    end
    prev_start = tx_start;
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    rd = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk);
    rd = 1'b0; addr = 32'h0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    bus_read(CON, d);
    total++; if (d !== 32'h80) begin bad++; $display("FAIL rst_con got=%h exp=80", d); end
    bus_read(RXD, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_rxd got=%h exp=0", d); end
  endtask

  task automatic test_single_tx();
    logic [31:0] d;
    int n, s0;
    busy_len = 5208;
    s0 = starts;
    exp_q.push_back(8'h2D);
    bus_write(TXD, 32'h2D);
    n = 0;
    while (!tx_busy && n < 20) begin @(negedge clk); n++; end
    total++; if (starts != s0 + 1 || !tx_busy) begin bad++; $display("FAIL single_start got=%0d exp=%0d", starts - s0, 1); end
    n = 0;
    while (tx_busy && n < 6000) begin @(negedge clk); n++; end
    total++; if (tx_busy) begin bad++; $display("FAIL single_busy_timeout got=1 exp=0"); end
    repeat (2) @(negedge clk);
    bus_read(CON, d);
    total++; if (d !== 32'h90) begin bad++; $display("FAIL con_after_tx got=%h exp=90", d); end
    bus_read(CON, d);
    total++; if (d !== 32'h80) begin bad++; $display("FAIL con_done_cleared got=%h exp=80", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    busy_len = 12;
    hold_busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      bus_write(TXD, 32'(i));
    end
    bus_read(CON, d);
    total++; if (d !== 32'h44) begin bad++; $display("FAIL con_ovf_full got=%h exp=44", d); end
    hold_busy = 1'b0;
    repeat (120) @(negedge clk);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ovf_drain got=%0d exp=0 left", exp_q.size()); end
    bus_read(CON, d);
    total++; if (d !== 32'h90) begin bad++; $display("FAIL con_after_drain got=%h exp=90", d); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d;
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'hB0 + 8'(i));
      bus_write(TXD, 32'hB0 + 32'(i));
    end
    exp_q.push_back(8'h66);
    @(negedge clk);
    hold_busy = 1'b0; wr = 1'b1; addr = TXD; wdata = 32'h66;
    @(negedge clk);
    wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    bus_read(CON, d);
    total++; if (d !== 32'h04) begin bad++; $display("FAIL con_pushpop_full got=%h exp=04", d); end
    repeat (150) @(negedge clk);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL pushpop_drain got=%0d exp=0 left", exp_q.size()); end
    bus_read(CON, d);
    total++; if (d !== 32'h90) begin bad++; $display("FAIL con_pushpop_end got=%h exp=90", d); end
  endtask

  task automatic test_rx_read();
    logic [31:0] d;
    rx_pulse(8'h49);
    bus_read(RXD, d);
    total++; if (d !== 32'h49) begin bad++; $display("FAIL rxd_read got=%h exp=49", d); end
    bus_read(CON, d);
    total++; if (d !== 32'h80) begin bad++; $display("FAIL con_rx_cleared got=%h exp=80", d); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    rx_pulse(8'h49);
    rx_pulse(8'h82);
    bus_read(CON, d);
    total++; if (d !== 32'hA8) begin bad++; $display("FAIL con_overrun got=%h exp=a8", d); end
    bus_read(RXD, d);
    total++; if (d !== 32'h82) begin bad++; $display("FAIL rxd_overwrite got=%h exp=82", d); end
    bus_read(CON, d);
    total++; if (d !== 32'h80) begin bad++; $display("FAIL con_ovr_cleared got=%h exp=80", d); end
  endtask

  task automatic test_rx_same_cycle();
    logic [31:0] d;
    rx_pulse(8'h11);
    @(negedge clk);
    rd = 1'b1; addr = RXD; rx_valid = 1'b1; rx_data = 8'h22;
    #1 d = rdata;
    @(negedge clk);
    rd = 1'b0; addr = 32'h0; rx_valid = 1'b0;
    total++; if (d !== 32'h11) begin bad++; $display("FAIL rxd_same_cycle got=%h exp=11", d); end
    bus_read(CON, d);
    total++; if (d !== 32'h88) begin bad++; $display("FAIL con_same_cycle got=%h exp=88", d); end
    bus_read(RXD, d);
    total++; if (d !== 32'h22) begin bad++; $display("FAIL rxd_new_byte got=%h exp=22", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(CON, 32'h2);
    rx_pulse(8'h7E);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", irq); end
    bus_read(RXD, d);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b exp=1", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", irq); end
    bus_write(CON, 32'h0);
  endtask

  task automatic test_reset_mid();
    int n, s0;
    busy_len = 50;
    hold_busy = 1'b1;
    exp_q.push_back(8'hA1);
    bus_write(TXD, 32'hA1);
    bus_write(TXD, 32'hA2);
    bus_write(TXD, 32'hA3);
    hold_busy = 1'b0;
    n = 0;
    while (busy_cnt == 0 && n < 20) begin @(negedge clk); n++; end
    total++; if (busy_cnt == 0) begin bad++; $display("FAIL mid_busy_timeout got=0 exp=busy"); end
    repeat (5) @(negedge clk);
    s0 = starts;
    @(negedge clk);
    reset = 1'b1; rd = 1'b1; addr = CON;
    #1;
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL mid_rst_start got=%b exp=0", tx_start); end
    total++; if (rdata !== 32'h80) begin bad++; $display("FAIL mid_rst_con got=%h exp=80", rdata); end
    @(negedge clk);
    reset = 1'b0; rd = 1'b0; addr = 32'h0;
    repeat (150) @(negedge clk);
    total++; if (starts != s0) begin bad++; $display("FAIL mid_rst_restart got=%0d exp=0", starts - s0); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mid_rst_queue got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    rx_data = 8'h0; rx_valid = 1'b0; hold_busy = 1'b0; busy_len = 10;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single_tx();
    test_overflow();
    test_push_pop_full();
    test_rx_read();
    test_rx_overrun();
    test_rx_same_cycle();
    test_irq();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
